// File: rtl/dcache_flush_ctrl_pkg.sv
// Shared types and defaults for the dcache flush controller.
// FSM state encoding and parameter defaults.
package dcache_flush_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } flush_state_e;

  localparam int unsigned CNT_WIDTH_DEF      = 32;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 4096;

endpackage

// File: rtl/dcache_flush_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear has priority over increment; holds at all ones.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  // count up, stick at all ones, clear wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/dcache_flush_ctrl.sv
// Dcache management-port controller: drain, flush, ack, enable.
// Optional flush watchdog built when DCACHE_FLUSH_WDOG_EN is defined.
import dcache_flush_ctrl_pkg::*;

module dcache_flush_ctrl #(
  parameter int unsigned CNT_WIDTH      = CNT_WIDTH_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_req_i,
  output logic                 flush_req_ready_o,
  output logic                 flush_done_o,
  output logic                 busy_o,
  input  logic                 csr_dcache_en_i,
  output logic                 dcache_enable_o,
  output logic                 dcache_flush_o,
  input  logic                 dcache_flushing_i,
  input  logic                 dcache_flush_ack_i,
  input  logic                 dcache_miss_i,
  input  logic                 wbuffer_empty_i,
  input  logic                 miss_clr_i,
  output logic [CNT_WIDTH-1:0] miss_cnt_o,
  output logic                 flush_timeout_o
);

  flush_state_e state_q;
  logic         en_q;
  logic         dis_pend_q;
  logic         flush_q;
  logic         done_q;
  logic         busy_q;
  logic         dis_evt;
  logic         trigger;
  logic         unused_flushing;

  // flushing is informational only; ack alone ends a flush
  assign unused_flushing = dcache_flushing_i;

  assign dis_evt = en_q & ~csr_dcache_en_i;
  assign trigger = (state_q == IDLE) &
                   (flush_req_i | dis_evt);

  assign flush_req_ready_o = (state_q == IDLE) & flush_req_i;
  assign flush_done_o      = done_q;
  assign busy_o            = busy_q;
  assign dcache_enable_o   = en_q;
  assign dcache_flush_o    = flush_q;

  // flush sequencer with registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      en_q       <= 1'b0;
      dis_pend_q <= 1'b0;
      flush_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (csr_dcache_en_i && !en_q) begin
            en_q <= 1'b1;
          end
          if (trigger) begin
            state_q    <= DRAIN;
            busy_q     <= 1'b1;
            dis_pend_q <= dis_evt;
          end
        end
        DRAIN: begin
          if (wbuffer_empty_i) begin
            state_q <= FLUSH;
            flush_q <= 1'b1;
          end
        end
        FLUSH: begin
          if (flush_q && dcache_flush_ack_i) begin
            state_q <= DONE;
            flush_q <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (dis_pend_q) begin
            en_q       <= 1'b0;
            dis_pend_q <= 1'b0;
          end
        end
      endcase
    end
  end

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_miss_cnt (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .clr   (miss_clr_i),
    .inc   (dcache_miss_i),
    .cnt   (miss_cnt_o)
  );

`ifdef DCACHE_FLUSH_WDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            in_flush;
  logic            tmo_q;

  assign in_flush        = (state_q == FLUSH);
  assign flush_timeout_o = tmo_q;

  sat_counter #(
    .WIDTH (WD_W)
  ) u_wdog (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .clr   (~in_flush),
    .inc   (in_flush),
    .cnt   (wd_cnt)
  );

  // sticky timeout, cleared by the next accepted trigger
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_q <= 1'b0;
    end else if (trigger) begin
      tmo_q <= 1'b0;
    end else if (in_flush && !dcache_flush_ack_i &&
                 (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1))) begin
      tmo_q <= 1'b1;
    end
  end
`else
  localparam int unsigned UNUSED_TMO = TIMEOUT_CYCLES;
  assign flush_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_dcache_flush_ctrl.sv
// Scoreboard bench for dcache_flush_ctrl.
// Stimulus queues expected flush edges; monitor compares.
module tb_dcache_flush_ctrl;

  localparam int CW = 4;
  localparam int EV_RISE = 1;
  localparam int EV_DONE = 2;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush_req, ready, done, busy;
  logic csr_en, en, flush, flushing, ack;
  logic miss, wbuf, clr, tmo;
  logic [CW-1:0] miss_cnt;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  ev_t  exp_q[$];
  logic flush_prev = 1'b0;

  dcache_flush_ctrl #(
    .CNT_WIDTH      (CW),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .flush_req_i        (flush_req),
    .flush_req_ready_o  (ready),
    .flush_done_o       (done),
    .busy_o             (busy),
    .csr_dcache_en_i    (csr_en),
    .dcache_enable_o    (en),
    .dcache_flush_o     (flush),
    .dcache_flushing_i  (flushing),
    .dcache_flush_ack_i (ack),
    .dcache_miss_i      (miss),
    .wbuffer_empty_i    (wbuf),
    .miss_clr_i         (clr),
    .miss_cnt_o         (miss_cnt),
    .flush_timeout_o    (tmo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL sim_timeout: got no finish, expected finish");
    $fatal(1);
  end

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic expect_ev(int k, int c);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic mon_ev(int k);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_ev: got kind %0d at %0d, expected none",
               k, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != cyc) begin
        errors++;
        $display("FAIL ev_order: got kind %0d at %0d expected kind %0d at %0d",
                 k, cyc, e.kind, e.cyc);
      end
    end
  endtask

  // monitor: flush rising edges and done pulses
  always @(negedge clk) begin
    if (rst_n) begin
      if (flush && !flush_prev) mon_ev(EV_RISE);
      if (done) mon_ev(EV_DONE);
      flush_prev = flush;
    end else begin
      flush_prev = 1'b0;
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int c0;

  initial begin
    rst_n = 1'b0; flush_req = 0; csr_en = 0; flushing = 0;
    ack = 0; miss = 0; wbuf = 1; clr = 0;
    step(3);
    chk("rst_flush", flush, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_en", en, 0);
    chk("rst_miss", miss_cnt, 0);
    chk("rst_tmo", tmo, 0);
    rst_n = 1'b1;
    step(2);

    // basic: accept c0, ack c0+5
    step(); c0 = cyc; flush_req = 1;
    expect_ev(EV_RISE, c0 + 2);
    expect_ev(EV_DONE, c0 + 6);
    #1 chk("t1_ready", ready, 1);
    step(); flush_req = 0;
    chk("t1_busy", busy, 1);
    step(); flushing = 1;
    step(2);
    chk("t1_flush_hi", flush, 1);
    step(); ack = 1;
    step(); ack = 0; flushing = 0;
    chk("t1_flush_lo", flush, 0);
    chk("t1_done", done, 1);
    step();
    chk("t1_idle", busy, 0);
    chk("t1_tmo", tmo, 0);

    // slow drain: wbuffer busy 10 cycles
    step(); c0 = cyc; flush_req = 1; wbuf = 0;
    expect_ev(EV_RISE, c0 + 11);
    expect_ev(EV_DONE, c0 + 14);
    step(); flush_req = 0;
    step(8);
    chk("t2_no_flush", flush, 0);
    step(); wbuf = 1;
    step();
    step(2); ack = 1;
    step(); ack = 0;
    step(2);

    // stray ack in IDLE and DRAIN ignored
    step(); ack = 1;
    step(); ack = 0;
    chk("t6_idle", busy, 0);
    step(); c0 = cyc; flush_req = 1;
    expect_ev(EV_RISE, c0 + 2);
    expect_ev(EV_DONE, c0 + 5);
    step(); flush_req = 0; ack = 1;
    step(); ack = 0;
    step();
    step(); ack = 1;
    step(); ack = 0;
    step(2);

    // CSR disable triggers auto flush
    step(); csr_en = 1;
    chk("t3_en_lag", en, 0);
    step();
    chk("t3_en_up", en, 1);
    step(); c0 = cyc; csr_en = 0;
    expect_ev(EV_RISE, c0 + 2);
    expect_ev(EV_DONE, c0 + 5);
    #1 chk("t3_no_ready", ready, 0);
    step();
    chk("t3_en_drain", en, 1);
    step(2);
    step(); ack = 1;
    step(); ack = 0;
    chk("t3_en_done", en, 1);
    step();
    chk("t3_en_off", en, 0);
    step(3);

    // request + disable in same cycle: one flush
    step(); csr_en = 1;
    step();
    chk("t4_en_up", en, 1);
    step(); c0 = cyc; flush_req = 1; csr_en = 0;
    expect_ev(EV_RISE, c0 + 2);
    expect_ev(EV_DONE, c0 + 4);
    #1 chk("t4_ready", ready, 1);
    step(); flush_req = 0;
    step();
    step(); ack = 1;
    step(); ack = 0;
    step();
    chk("t4_en_off", en, 0);
    step(4);

    // request while busy is held, served after DONE
    step(); c0 = cyc; flush_req = 1;
    expect_ev(EV_RISE, c0 + 2);
    expect_ev(EV_DONE, c0 + 4);
    expect_ev(EV_RISE, c0 + 7);
    expect_ev(EV_DONE, c0 + 9);
    step();
    #1 chk("t5_nordy_busy", ready, 0);
    step();
    step(); ack = 1;
    step(); ack = 0;
    #1 chk("t5_nordy_done", ready, 0);
    step();
    #1 chk("t5_ready2", ready, 1);
    step(); flush_req = 0;
    step();
    step(); ack = 1;
    step(); ack = 0;
    step(2);

    // reset mid-flush drops flush at once
    step(); c0 = cyc; flush_req = 1;
    expect_ev(EV_RISE, c0 + 2);
    step(); flush_req = 0;
    step(2);
    chk("t8_flush_hi", flush, 1);
    rst_n = 1'b0;
    #1 chk("t8_rst_drop", flush, 0);
    chk("t8_rst_busy", busy, 0);
    step(); rst_n = 1'b1;
    step(2);
    chk("t8_idle", busy, 0);

    // miss counter saturation and clear priority
    step(); clr = 1;
    step(); clr = 0; miss = 1;
    step(10);
    chk("t7_miss10", miss_cnt, 10);
    step(10);
    chk("t7_miss_sat", miss_cnt, 15);
    clr = 1;
    step();
    chk("t7_clr_pri", miss_cnt, 0);
    clr = 0;
    step(3);
    chk("t7_miss3", miss_cnt, 3);
    miss = 0;
    step(2);

`ifdef DCACHE_FLUSH_WDOG_EN
    // watchdog after 8 FLUSH cycles, clears on next trigger
    step(); c0 = cyc; flush_req = 1;
    expect_ev(EV_RISE, c0 + 2);
    expect_ev(EV_DONE, c0 + 13);
    expect_ev(EV_RISE, c0 + 17);
    expect_ev(EV_DONE, c0 + 20);
    step(); flush_req = 0;
    step(8);
    chk("wd_not_yet", tmo, 0);
    step();
    chk("wd_set", tmo, 1);
    chk("wd_flush_hi", flush, 1);
    step(2); ack = 1;
    step(); ack = 0;
    step();
    chk("wd_sticky", tmo, 1);
    step(); flush_req = 1;
    step(); flush_req = 0;
    chk("wd_cleared", tmo, 0);
    step(2);
    step(); ack = 1;
    step(); ack = 0;
    step(2);
`else
    chk("wd_tied", tmo, 0);
`endif

    step(5);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_ev: got %0d pending, expected 0",
               exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
